// File: rtl/alu_cmd_pkg.sv
// Shared constants and types for the ALU command sequencer: opcodes, FSM states
// and default sizing.
package alu_cmd_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo
  import alu_cmd_pkg::*;
#(
  parameter  int DW    = 2 * W_DEF + 3,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;

  // NOTE: storage is deliberately not reset; only pointers and count define
  // validity, which keeps the array a plain register file / RAM.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PW'(1);
      if (i_pop)  r_rp <= r_rp + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: queues ALU commands, issues them one at a time to an
// external combinational ALU and returns registered responses in order.
module alu_cmd_seq
  import alu_cmd_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_c,
  input  logic [1:0]   cmd_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_c,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_o,
  input  logic         alu_flag,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_o,
  output logic         rsp_flag,
  output logic [1:0]   rsp_sel,
  output logic         rsp_err
);

  localparam int DW = 2 * W + 3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] w_count;
  logic [DW-1:0] w_head;
  logic [DW-1:0] w_cmd;
  logic [DW-1:0] w_src;
  logic [1:0]    w_src_sel;
  logic          w_push;
  logic          w_wr;
  logic          w_pop;
  logic          w_enter;
  logic          w_bypass;
  logic          w_iss_rsv;

  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  logic          r_alu_c;
  logic [1:0]    r_alu_sel;
  logic [1:0]    r_iss_sel;
  logic [W-1:0]  r_rsp_o;
  logic          r_rsp_flag;
  logic [1:0]    r_rsp_sel;
  logic          r_rsp_err;

  assign cmd_ready = rst_n && (w_count < FULL);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_cmd     = {cmd_sel, cmd_c, cmd_b, cmd_a};

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr),
    .i_pop   (w_pop),
    .i_wdata (w_cmd),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case leaves
  // w_next unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_count != '0) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) w_next = (w_count != '0 || w_push) ? ST_ISSUE : ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // A command pushed on the handshake cycle into an empty FIFO is issued
  // straight from the input bus instead of being written and popped.
  always_comb begin
    rsp_valid = (r_state == ST_RESP);
    w_enter   = (w_next == ST_ISSUE);
    w_bypass  = w_enter && (w_count == '0);
    w_pop     = w_enter && !w_bypass;
    w_wr      = w_push && !w_bypass;
    w_src     = w_bypass ? w_cmd : w_head;
  end

  assign w_src_sel = w_src[DW-1 -: 2];
  assign w_iss_rsv = (r_iss_sel == OP_RSV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_c    <= 1'b0;
      r_alu_sel  <= OP_ADD;
      r_iss_sel  <= OP_ADD;
      r_rsp_o    <= '0;
      r_rsp_flag <= 1'b0;
      r_rsp_sel  <= OP_ADD;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_enter) begin
        r_iss_sel <= w_src_sel;
        // Reserved opcodes leave the ALU drive untouched.
        if (w_src_sel != OP_RSV) begin
          r_alu_a   <= w_src[W-1:0];
          r_alu_b   <= w_src[2*W-1:W];
          r_alu_c   <= w_src[2*W];
          r_alu_sel <= w_src_sel;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_rsp_o    <= w_iss_rsv ? '0 : alu_o;
        r_rsp_flag <= w_iss_rsv ? 1'b0 : alu_flag;
        r_rsp_sel  <= r_iss_sel;
        r_rsp_err  <= w_iss_rsv;
      end
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_c    = r_alu_c;
  assign alu_sel  = r_alu_sel;
  assign rsp_o    = r_rsp_o;
  assign rsp_flag = r_rsp_flag;
  assign rsp_sel  = r_rsp_sel;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed vector table, streaming,
// backpressure and reset sequences, then random traffic against a queue model.
module tb_alu_cmd_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   sel;
    logic         c;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } cmd_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [1:0]   sel;
    logic [W-1:0] o;
    logic         flag;
    logic         err;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_c;
  logic [1:0]   cmd_sel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_c;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_o;
  logic         alu_flag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_o;
  logic         rsp_flag;
  logic [1:0]   rsp_sel;
  logic         rsp_err;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_rsp = 0;
  int           cyc = 0;
  cmd_t         exp_q[$];
  int           hs_q[$];
  logic         held = 1'b0;
  logic [W+3:0] held_v = '0;
  vec_t         vt[12];

  alu_cmd_seq #(.W(W), .DEPTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_sel   (alu_sel),
    .alu_o     (alu_o),
    .alu_flag  (alu_flag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_o     (rsp_o),
    .rsp_flag  (rsp_flag),
    .rsp_sel   (rsp_sel),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Team ALU: add -> carry out, sub -> borrow out, mul -> high half nonzero.
  // The reserved code returns junk so a leak into the response is visible.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic [1:0] sel);
    logic [2*W-1:0] p;
    case (sel)
      2'b00:   return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      2'b01:   return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
      2'b10: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return {|p[2*W-1:W], p[W-1:0]};
      end
      default: return {1'b1, a ^ b};
    endcase
  endfunction

  // Expected {o, flag, sel, err} for an accepted command.
  function automatic logic [W+3:0] model_rsp(input cmd_t m);
    logic [W:0] r;
    if (m.sel == 2'b11) return {{W{1'b0}}, 1'b0, 2'b11, 1'b1};
    r = alu_ref(m.a, m.b, m.c, m.sel);
    return {r[W-1:0], r[W], m.sel, 1'b0};
  endfunction

  assign {alu_flag, alu_o} = alu_ref(alu_a, alu_b, alu_c, alu_sel);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Handshakes are known from stable signals half a cycle before the edge.
  always @(negedge clk) begin
    cmd_t m;
    cmd_t nc;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held)
        check("rsp_hold", {rsp_valid, rsp_o, rsp_flag, rsp_sel, rsp_err}, {1'b1, held_v});
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        n_rsp++;
        hs_q.push_back(cyc);
        check("rsp_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          m = exp_q.pop_front();
          check("rsp_data", {rsp_o, rsp_flag, rsp_sel, rsp_err}, model_rsp(m));
        end
      end else if (rsp_valid) begin
        held   = 1'b1;
        held_v = {rsp_o, rsp_flag, rsp_sel, rsp_err};
      end else begin
        held = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        nc = {cmd_sel, cmd_c, cmd_b, cmd_a};
        exp_q.push_back(nc);
      end
    end
  end

  // Called and returns at posedge+1; holds the command until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic [1:0] sel);
    bit acc = 1'b0;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_sel = sel; cmd_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("send_accept", 64'(acc), 1);
  endtask

  task automatic wait_rsp_count(input int target, input int limit, input string name);
    for (int k = 0; k < limit && n_rsp < target; k++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(n_rsp >= target), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0;
    int         acc;
    logic       rdy_last;
    logic [1:0] last_sel;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = 1'b0;
    cmd_sel = 2'b00; rsp_ready = 1'b0;

    vt[0]  = '{8'h01, 8'h01, 1'b0, 2'b00, 8'h02, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 8'hFF, 1'b0, 2'b00, 8'hFE, 1'b1, 1'b0};
    vt[2]  = '{8'hFF, 8'hFF, 1'b0, 2'b01, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{8'hFF, 8'hFF, 1'b0, 2'b10, 8'h01, 1'b1, 1'b0};
    vt[4]  = '{8'h55, 8'hAA, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0};
    vt[5]  = '{8'h55, 8'hAA, 1'b0, 2'b01, 8'hAB, 1'b1, 1'b0};
    vt[6]  = '{8'h55, 8'hAA, 1'b0, 2'b10, 8'h72, 1'b1, 1'b0};
    vt[7]  = '{8'h12, 8'h34, 1'b0, 2'b11, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{8'h7F, 8'h00, 1'b1, 2'b00, 8'h80, 1'b0, 1'b0};
    vt[9]  = '{8'h10, 8'h0F, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0};
    vt[10] = '{8'h00, 8'h00, 1'b1, 2'b01, 8'hFF, 1'b1, 1'b0};
    vt[11] = '{8'h0F, 8'h11, 1'b1, 2'b10, 8'hFF, 1'b0, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {rsp_valid, rsp_o, rsp_flag, rsp_sel, rsp_err,
                          alu_a, alu_b, alu_c, alu_sel}, 64'd0);
    check("rst_cmd_ready_low", 64'(cmd_ready), 0);
    rst_n = 1'b1;
    #1;
    check("rst_cmd_ready_high", 64'(cmd_ready), 1);
    @(posedge clk); #1;

    // Directed vectors, one at a time from idle: latency N+2 and values
    rsp_ready = 1'b1;
    last_sel  = 2'b00;
    for (int i = 0; i < 12; i++) begin
      send(vt[i].a, vt[i].b, vt[i].c, vt[i].sel);
      check($sformatf("v%0d_valid_n0", i), 64'(rsp_valid), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_n1", i), 64'(rsp_valid), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_n2", i), 64'(rsp_valid), 1);
      check($sformatf("v%0d_rsp", i), {rsp_o, rsp_flag, rsp_sel, rsp_err},
            {vt[i].o, vt[i].flag, vt[i].sel, vt[i].err});
      if (vt[i].sel == 2'b11) begin
        check($sformatf("v%0d_alu_sel_kept", i), 64'(alu_sel), 64'(last_sel));
      end else begin
        check($sformatf("v%0d_alu_sel", i), 64'(alu_sel), 64'(vt[i].sel));
        last_sel = vt[i].sel;
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_after_hs", i), 64'(rsp_valid), 0);
    end

    // Same vectors streamed back-to-back: one response every 2 cycles
    hs_q.delete();
    n0 = n_rsp;
    for (int i = 0; i < 12; i++) send(vt[i].a, vt[i].b, vt[i].c, vt[i].sel);
    wait_rsp_count(n0 + 12, 200, "stream_done");
    check("stream_count", 64'(hs_q.size()), 12);
    for (int i = 1; i < hs_q.size(); i++)
      check($sformatf("stream_gap_%0d", i), 64'(hs_q[i] - hs_q[i-1]), 2);

    // Backpressure: six offers, five fit (one in flight plus four queued)
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    acc = 0;
    rdy_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 8'(16 * i + 3); cmd_b = 8'(i + 7); cmd_c = 1'(i % 2);
      cmd_sel = 2'(i % 3); cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) acc++;
      rdy_last = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 64'(acc), 5);
    check("bp_sixth_ready", 64'(rdy_last), 0);
    check("bp_rsp_valid", 64'(rsp_valid), 1);
    n0 = n_rsp;
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_rsp_while_stalled", 64'(n_rsp), 64'(n0));
    rsp_ready = 1'b1;
    wait_rsp_count(n0 + 5, 100, "bp_drain");
    repeat (4) @(posedge clk);
    #1;
    check("bp_drain_count", 64'(n_rsp), 64'(n0 + 5));
    check("bp_queue_empty", 64'(exp_q.size()), 0);

    // Reset while a response is pending with three commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 1), 8'(2 * i + 1), 1'b0, 2'(i % 3));
    check("prerst_rsp_valid", 64'(rsp_valid), 1);
    rst_n = 1'b0;
    cmd_a = 8'hEE; cmd_b = 8'h11; cmd_sel = 2'b00; cmd_valid = 1'b1;
    #1;
    check("inrst_cmd_ready", 64'(cmd_ready), 0);
    @(posedge clk); #1;
    check("postrst_rsp_valid", 64'(rsp_valid), 0);
    check("postrst_regs", {rsp_o, rsp_flag, rsp_sel, rsp_err, alu_a, alu_b, alu_c, alu_sel}, 64'd0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("postrst_cmd_ready", 64'(cmd_ready), 1);
    n0 = n_rsp;
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("postrst_no_rsp", 64'(n_rsp), 64'(n0));
    check("postrst_idle", 64'(rsp_valid), 0);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_c     = 1'($urandom_range(0, 1));
      cmd_sel   = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || rsp_valid); k++) begin
      @(posedge clk); #1;
    end
    check("rand_drain_empty", 64'(exp_q.size()), 0);
    check("rand_drain_idle", 64'(rsp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
